// File: rtl/negf_share_arbiter.sv
// Round-robin sharing of one elastic 1-in/1-out arithmetic unit among NUM_IN requesters.
// A tag FIFO remembers who issued each operand so results are steered back in issue order.
module negf_share_arbiter #(
  parameter int DATA_TYPE  = 32,
  parameter int NUM_IN     = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_IN*DATA_TYPE-1:0]   ins,
  input  logic [NUM_IN-1:0]             ins_valid,
  output logic [NUM_IN-1:0]             ins_ready,
  output logic [DATA_TYPE-1:0]          unit_ins,
  output logic                          unit_ins_valid,
  input  logic                          unit_ins_ready,
  input  logic [DATA_TYPE-1:0]          unit_outs,
  input  logic                          unit_outs_valid,
  output logic                          unit_outs_ready,
  output logic [NUM_IN*DATA_TYPE-1:0]   outs,
  output logic [NUM_IN-1:0]             outs_valid,
  input  logic [NUM_IN-1:0]             outs_ready,
  output logic                          err
);

  localparam int TAG_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [TAG_W-1:0] LAST_IDX = TAG_W'(NUM_IN - 1);
  localparam logic [TAG_W-1:0] ONE_TAG  = TAG_W'(1'b1);
  localparam logic [TAG_W-1:0] ZERO_TAG = {TAG_W{1'b0}};
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [PTR_W-1:0] ONE_PTR  = PTR_W'(1'b1);
  localparam logic [PTR_W-1:0] ZERO_PTR = {PTR_W{1'b0}};
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] ZERO_CNT = {CNT_W{1'b0}};

  logic [TAG_W-1:0] rr_ptr_r;
  logic             lock_r;
  logic [TAG_W-1:0] locked_idx_r;
  logic [TAG_W-1:0] tag_mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W-1:0] wr_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             err_r;

  logic [TAG_W-1:0] scan_idx_s;
  logic             scan_hit_s;
  logic [TAG_W-1:0] rr_grant_s;
  logic [TAG_W-1:0] grant_s;
  logic [TAG_W-1:0] head_s;
  logic             full_s;
  logic             empty_s;
  logic             push_s;
  logic             pop_s;

  // Round-robin scan starting at rr_ptr; the index wraps explicitly so any NUM_IN works.
  always_comb begin
    rr_grant_s = rr_ptr_r;
    scan_hit_s = 1'b0;
    scan_idx_s = rr_ptr_r;
    for (int k = 0; k < NUM_IN; k++) begin
      if (!scan_hit_s && ins_valid[scan_idx_s]) begin
        rr_grant_s = scan_idx_s;
        scan_hit_s = 1'b1;
      end else begin
        rr_grant_s = rr_grant_s;
      end
      scan_idx_s = (scan_idx_s == LAST_IDX) ? ZERO_TAG : scan_idx_s + ONE_TAG;
    end
  end

  // A stalled operand stays granted so unit_ins is stable until the unit takes it.
  always_comb begin
    if (lock_r) begin
      grant_s = locked_idx_r;
    end else begin
      grant_s = rr_grant_s;
    end
    full_s  = (count_r == FULL_CNT);
    empty_s = (count_r == ZERO_CNT);
    head_s  = tag_mem_r[rd_ptr_r];
  end

  // Issue path; everything is held low while reset is asserted.
  always_comb begin
    unit_ins           = ins[int'(grant_s)*DATA_TYPE +: DATA_TYPE];
    unit_ins_valid     = rst & ins_valid[grant_s] & ~full_s;
    ins_ready          = {NUM_IN{1'b0}};
    ins_ready[grant_s] = rst & unit_ins_ready & ~full_s;
    push_s             = unit_ins_valid & unit_ins_ready;
  end

  // Return path: the FIFO head selects which consumer sees the result.
  always_comb begin
    outs               = {NUM_IN{unit_outs}};
    outs_valid         = {NUM_IN{1'b0}};
    outs_valid[head_s] = rst & unit_outs_valid & ~empty_s;
    unit_outs_ready    = rst & outs_ready[head_s] & ~empty_s;
    pop_s              = unit_outs_valid & unit_outs_ready;
    err                = err_r;
  end

  // Arbitration state: advance the pointer on acceptance, lock on a stall.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_r     <= ZERO_TAG;
      lock_r       <= 1'b0;
      locked_idx_r <= ZERO_TAG;
    end else if (push_s) begin
      rr_ptr_r     <= (grant_s == LAST_IDX) ? ZERO_TAG : grant_s + ONE_TAG;
      lock_r       <= 1'b0;
    end else if (unit_ins_valid) begin
      lock_r       <= 1'b1;
      locked_idx_r <= grant_s;
    end
  end

  // Tag FIFO storage and pointers; a full FIFO never accepts a push, even alongside a pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        tag_mem_r[i] <= ZERO_TAG;
      end
      rd_ptr_r <= ZERO_PTR;
      wr_ptr_r <= ZERO_PTR;
      count_r  <= ZERO_CNT;
    end else begin
      if (push_s) begin
        tag_mem_r[wr_ptr_r] <= grant_s;
        wr_ptr_r <= (wr_ptr_r == LAST_PTR) ? ZERO_PTR : wr_ptr_r + ONE_PTR;
      end
      if (pop_s) begin
        rd_ptr_r <= (rd_ptr_r == LAST_PTR) ? ZERO_PTR : rd_ptr_r + ONE_PTR;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + ONE_CNT;
        2'b01:   count_r <= count_r - ONE_CNT;
        default: count_r <= count_r;
      endcase
    end
  end

  // Sticky flag for a result that has no recorded owner.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_r <= 1'b0;
    end else if (unit_outs_valid && empty_s) begin
      err_r <= 1'b1;
    end
  end

endmodule

// File: tb/tb_negf_share_arbiter.sv
// Directed bench for negf_share_arbiter: a queue-based reference model is compared every
// cycle, and hand-computed issue/return sequences pin the model for each scenario.
module tb_negf_share_arbiter;

  localparam int NI = 4;
  localparam int DW = 32;
  localparam int FD = 4;

  logic              clk;
  logic              rst;
  logic [NI*DW-1:0]  ins;
  logic [NI-1:0]     ins_valid;
  logic [NI-1:0]     ins_ready;
  logic [DW-1:0]     unit_ins;
  logic              unit_ins_valid;
  logic              unit_ins_ready;
  logic [DW-1:0]     unit_outs;
  logic              unit_outs_valid;
  logic              unit_outs_ready;
  logic [NI*DW-1:0]  outs;
  logic [NI-1:0]     outs_valid;
  logic [NI-1:0]     outs_ready;
  logic              err;

  int checks;
  int errors;

  // reference model state
  int  rr_m;
  int  lock_m;
  int  tagq[$];
  bit  err_m;
  logic [DW-1:0] issue_log[$];
  logic [NI-1:0] ret_log[$];

  negf_share_arbiter #(.DATA_TYPE(DW), .NUM_IN(NI), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst(rst),
    .ins(ins), .ins_valid(ins_valid), .ins_ready(ins_ready),
    .unit_ins(unit_ins), .unit_ins_valid(unit_ins_valid), .unit_ins_ready(unit_ins_ready),
    .unit_outs(unit_outs), .unit_outs_valid(unit_outs_valid), .unit_outs_ready(unit_outs_ready),
    .outs(outs), .outs_valid(outs_valid), .outs_ready(outs_ready),
    .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Predict this cycle's outputs from the model, compare, then advance the model.
  task automatic model_check();
    int g;
    bit full;
    bit empty;
    bit e_uiv;
    bit e_uor;
    bit do_pop;
    logic [NI-1:0] e_ir;
    logic [NI-1:0] e_ov;
    if (!rst) begin
      rr_m = 0; lock_m = -1; tagq.delete(); err_m = 1'b0;
      chk("rst_uiv", {31'd0, unit_ins_valid}, 32'd0);
      chk("rst_ir", {28'd0, ins_ready}, 32'd0);
      chk("rst_ov", {28'd0, outs_valid}, 32'd0);
      chk("rst_uor", {31'd0, unit_outs_ready}, 32'd0);
      chk("rst_err", {31'd0, err}, 32'd0);
      return;
    end
    g = lock_m;
    if (g < 0) begin
      for (int k = 0; k < NI; k++) begin
        if (g < 0 && ins_valid[(rr_m + k) % NI]) g = (rr_m + k) % NI;
      end
    end
    full  = (tagq.size() >= FD);
    empty = (tagq.size() == 0);
    e_uiv = (g >= 0) && ins_valid[g] && !full;
    chk("m_uiv", {31'd0, unit_ins_valid}, {31'd0, e_uiv});
    if (e_uiv) chk("m_uins", unit_ins, ins[g*DW +: DW]);
    if (g >= 0) begin
      e_ir = {NI{1'b0}};
      e_ir[g] = unit_ins_ready && !full;
      chk("m_ir", {28'd0, ins_ready}, {28'd0, e_ir});
    end
    e_ov  = {NI{1'b0}};
    e_uor = 1'b0;
    if (!empty) begin
      e_ov[tagq[0]] = unit_outs_valid;
      e_uor = outs_ready[tagq[0]];
    end
    chk("m_ov", {28'd0, outs_valid}, {28'd0, e_ov});
    chk("m_uor", {31'd0, unit_outs_ready}, {31'd0, e_uor});
    if (e_ov != {NI{1'b0}}) begin
      for (int i = 0; i < NI; i++) chk("m_outs", outs[i*DW +: DW], unit_outs);
    end
    chk("m_err", {31'd0, err}, {31'd0, err_m});
    if (unit_ins_valid && unit_ins_ready) issue_log.push_back(unit_ins);
    if (unit_outs_valid && unit_outs_ready) ret_log.push_back(outs_valid);
    do_pop = unit_outs_valid && e_uor;
    if (unit_outs_valid && empty) err_m = 1'b1;
    if (do_pop) void'(tagq.pop_front());
    if (e_uiv && unit_ins_ready) begin
      tagq.push_back(g);
      rr_m = (g + 1) % NI;
      lock_m = -1;
    end else if (e_uiv) begin
      lock_m = g;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    model_check();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_issue(input string name, input logic [DW-1:0] exp[$]);
    chk({name, "_n"}, issue_log.size(), exp.size());
    for (int i = 0; i < exp.size() && i < issue_log.size(); i++) chk(name, issue_log[i], exp[i]);
  endtask

  task automatic chk_ret(input string name, input logic [NI-1:0] exp[$]);
    chk({name, "_n"}, ret_log.size(), exp.size());
    for (int i = 0; i < exp.size() && i < ret_log.size(); i++)
      chk(name, {28'd0, ret_log[i]}, {28'd0, exp[i]});
  endtask

  initial begin
    checks = 0; errors = 0;
    rr_m = 0; lock_m = -1; err_m = 1'b0;
    for (int i = 0; i < NI; i++) ins[i*DW +: DW] = 32'h0000_0100 + 32'(i);
    rst = 1'b0; ins_valid = 4'hF; unit_ins_ready = 1'b1; unit_outs_valid = 1'b1;
    unit_outs = 32'hBF80_0000; outs_ready = 4'hF;
    #1;
    chk("reset_uiv", {31'd0, unit_ins_valid}, 32'd0);
    chk("reset_ir", {28'd0, ins_ready}, 32'd0);
    chk("reset_err", {31'd0, err}, 32'd0);
    tick(); tick();
    ins_valid = 4'h0; unit_outs_valid = 1'b0;
    rst = 1'b1;
    tick();

    // arbitration: all channels valid, results streaming back
    issue_log.delete(); ret_log.delete();
    ins_valid = 4'hF; tick();
    unit_outs_valid = 1'b1;
    for (int c = 0; c < 4; c++) tick();
    ins_valid = 4'h0; tick();
    unit_outs_valid = 1'b0; tick();
    chk_issue("arb_issue", '{32'h100, 32'h101, 32'h102, 32'h103, 32'h100});
    chk_ret("arb_ret", '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001});

    // lock: ch2 stalls, ch0 arrives but must wait
    issue_log.delete(); ret_log.delete();
    ins_valid = 4'b0100; unit_ins_ready = 1'b1; tick();
    unit_ins_ready = 1'b0; unit_outs_valid = 1'b1;
    #1 chk("lock_c1", unit_ins, 32'h102);
    tick();
    unit_outs_valid = 1'b0; ins_valid = 4'b0101;
    #1 chk("lock_c2", unit_ins, 32'h102);
    tick();
    #1 chk("lock_c3", unit_ins, 32'h102);
    tick();
    unit_ins_ready = 1'b1;
    #1 chk("lock_acc", unit_ins, 32'h102);
    tick();
    #1 chk("lock_next", unit_ins, 32'h100);
    tick();
    ins_valid = 4'h0; unit_outs_valid = 1'b1; tick(); tick();
    unit_outs_valid = 1'b0;
    chk_issue("lock_issue", '{32'h102, 32'h102, 32'h100});

    // full: four in flight blocks the fifth until a pop
    issue_log.delete(); ret_log.delete();
    ins_valid = 4'hF;
    for (int c = 0; c < 4; c++) tick();
    #1;
    chk("full_uiv", {31'd0, unit_ins_valid}, 32'd0);
    chk("full_ir", {28'd0, ins_ready}, 32'd0);
    unit_outs_valid = 1'b1; tick();
    unit_outs_valid = 1'b0;
    #1;
    chk("resume_uiv", {31'd0, unit_ins_valid}, 32'd1);
    chk("resume_uins", unit_ins, 32'h101);
    tick();
    ins_valid = 4'h0; unit_outs_valid = 1'b1;
    for (int c = 0; c < 3; c++) tick();
    chk_ret("full_ret", '{4'b0010, 4'b0100, 4'b1000, 4'b0001});

    // consumer stall on head tag 1
    outs_ready = 4'b1101;
    #1;
    chk("stall_uor", {31'd0, unit_outs_ready}, 32'd0);
    chk("stall_ov", {28'd0, outs_valid}, 32'h2);
    tick();
    #1 chk("stall_uor2", {31'd0, unit_outs_ready}, 32'd0);
    tick();
    outs_ready = 4'hF;
    #1 chk("release_uor", {31'd0, unit_outs_ready}, 32'd1);
    tick();
    unit_outs_valid = 1'b0; tick();

    // error: result with nothing in flight
    unit_outs_valid = 1'b1;
    #1;
    chk("err_uor", {31'd0, unit_outs_ready}, 32'd0);
    chk("err_ov", {28'd0, outs_valid}, 32'd0);
    chk("err_pre", {31'd0, err}, 32'd0);
    tick();
    chk("err_set", {31'd0, err}, 32'd1);
    unit_outs_valid = 1'b0; tick();
    chk("err_sticky", {31'd0, err}, 32'd1);

    // reset in the middle of traffic
    ins_valid = 4'hF; tick(); tick();
    unit_outs_valid = 1'b1;
    rst = 1'b0;
    #1;
    chk("mid_uiv", {31'd0, unit_ins_valid}, 32'd0);
    chk("mid_ir", {28'd0, ins_ready}, 32'd0);
    chk("mid_ov", {28'd0, outs_valid}, 32'd0);
    chk("mid_uor", {31'd0, unit_outs_ready}, 32'd0);
    chk("mid_err", {31'd0, err}, 32'd0);
    tick();
    unit_outs_valid = 1'b0; rst = 1'b1;
    #1;
    chk("post_uiv", {31'd0, unit_ins_valid}, 32'd1);
    chk("post_uins", unit_ins, 32'h100);
    tick();
    ins_valid = 4'h0; tick();
    unit_outs_valid = 1'b1; tick();
    unit_outs_valid = 1'b0; tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
